// File: rtl/move_grid.sv
// Cursor position block: turns debounced up/down/left/right levels into an
// (x, y) grid position with a single step on press, hold-to-repeat, wrap or
// clamp at the edges, and moved/blocked status pulses.
//
// Ports:
//   clock              system clock, all state changes on posedge
//   reset              asynchronous active-low reset
//   up/down/left/right button levels, synchronous to clock
//   x, y               current column / row (registered)
//   moved              one-cycle pulse: x or y changed on the last edge
//   blocked            one-cycle pulse: a step hit a clamp edge (WRAP=0 only)
module move_grid #(
   parameter int unsigned X_WIDTH       = 2,
   parameter int unsigned Y_WIDTH       = 2,
   parameter int unsigned X_MAX         = 3,
   parameter int unsigned Y_MAX         = 3,
   parameter int unsigned X_INIT        = 0,
   parameter int unsigned Y_INIT        = 0,
   parameter bit          WRAP          = 1'b1,
   parameter int unsigned REPEAT_DELAY  = 4,
   parameter int unsigned REPEAT_PERIOD = 2,
   parameter int unsigned CNT_WIDTH     = 16
) (
   input  logic               clock,
   input  logic               reset,
   input  logic               up,
   input  logic               down,
   input  logic               left,
   input  logic               right,
   output logic [X_WIDTH-1:0] x,
   output logic [Y_WIDTH-1:0] y,
   output logic               moved,
   output logic               blocked
);

   localparam logic [X_WIDTH-1:0]   X_LAST     = X_WIDTH'(X_MAX);
   localparam logic [Y_WIDTH-1:0]   Y_LAST     = Y_WIDTH'(Y_MAX);
   localparam logic [CNT_WIDTH-1:0] DELAY_LAST = CNT_WIDTH'(REPEAT_DELAY - 1);
   localparam logic [CNT_WIDTH-1:0] PER_LAST   = CNT_WIDTH'(REPEAT_PERIOD - 1);

   typedef enum logic [1:0] {S_IDLE, S_DELAY, S_REPEAT} state_t;

   state_t               state, state_n;
   logic [CNT_WIDTH-1:0] cnt, cnt_n;
   logic [3:0]           prev_dir;

   logic                 x_inc_c, x_dec_c, y_inc_c, y_dec_c;
   logic [3:0]           dir_c;
   logic                 active_c, step_c;
   logic [X_WIDTH-1:0]   x_step_c;
   logic [Y_WIDTH-1:0]   y_step_c;
   logic                 x_blk_c, y_blk_c;

   // Opposite buttons cancel per axis; {inc,dec} pairs uniquely encode {dx,dy}
   assign x_inc_c  = right & ~left;
   assign x_dec_c  = left & ~right;
   assign y_inc_c  = down & ~up;
   assign y_dec_c  = up & ~down;
   assign dir_c    = {x_inc_c, x_dec_c, y_inc_c, y_dec_c};
   assign active_c = |dir_c;

   // Press / hold-to-repeat sequencing
   always_comb begin
      state_n = state;
      cnt_n   = cnt;
      step_c  = 1'b0;
      unique case (state)
         S_IDLE: begin
            if (active_c) begin
               step_c  = 1'b1;
               cnt_n   = '0;
               state_n = S_DELAY;
            end
         end
         S_DELAY: begin
            if (!active_c) begin
               cnt_n   = '0;
               state_n = S_IDLE;
            end else if (dir_c != prev_dir) begin
               step_c = 1'b1;
               cnt_n  = '0;
            end else if (cnt == DELAY_LAST) begin
               step_c  = 1'b1;
               cnt_n   = '0;
               state_n = S_REPEAT;
            end else begin
               cnt_n = cnt + CNT_WIDTH'(1);
            end
         end
         S_REPEAT: begin
            if (!active_c) begin
               cnt_n   = '0;
               state_n = S_IDLE;
            end else if (dir_c != prev_dir) begin
               // A changed vector restarts the initial delay
               step_c  = 1'b1;
               cnt_n   = '0;
               state_n = S_DELAY;
            end else if (cnt == PER_LAST) begin
               step_c = 1'b1;
               cnt_n  = '0;
            end else begin
               cnt_n = cnt + CNT_WIDTH'(1);
            end
         end
         default: begin
            cnt_n   = '0;
            state_n = S_IDLE;
         end
      endcase
   end

   // Per-axis target position with wrap or clamp at the edges
   always_comb begin
      x_step_c = x;
      y_step_c = y;
      x_blk_c  = 1'b0;
      y_blk_c  = 1'b0;
      if (x_inc_c) begin
         if (x == X_LAST) begin
            if (WRAP) x_step_c = '0;
            else      x_blk_c  = 1'b1;
         end else begin
            x_step_c = x + X_WIDTH'(1);
         end
      end else if (x_dec_c) begin
         if (x == '0) begin
            if (WRAP) x_step_c = X_LAST;
            else      x_blk_c  = 1'b1;
         end else begin
            x_step_c = x - X_WIDTH'(1);
         end
      end
      if (y_inc_c) begin
         if (y == Y_LAST) begin
            if (WRAP) y_step_c = '0;
            else      y_blk_c  = 1'b1;
         end else begin
            y_step_c = y + Y_WIDTH'(1);
         end
      end else if (y_dec_c) begin
         if (y == '0) begin
            if (WRAP) y_step_c = Y_LAST;
            else      y_blk_c  = 1'b1;
         end else begin
            y_step_c = y - Y_WIDTH'(1);
         end
      end
   end

   // State, position and status registers
   always_ff @(posedge clock or negedge reset) begin
      if (!reset) begin
         state    <= S_IDLE;
         cnt      <= '0;
         prev_dir <= '0;
         x        <= X_WIDTH'(X_INIT);
         y        <= Y_WIDTH'(Y_INIT);
         moved    <= 1'b0;
         blocked  <= 1'b0;
      end else begin
         state    <= state_n;
         cnt      <= cnt_n;
         prev_dir <= dir_c;
         moved    <= step_c && ((x_step_c != x) || (y_step_c != y));
         blocked  <= step_c && (x_blk_c || y_blk_c);
         if (step_c) begin
            x <= x_step_c;
            y <= y_step_c;
         end
      end
   end

endmodule
